// File: rtl/ram4k_arbiter.sv
// ram4k_arbiter: shares one 4K x 16 RAM between requesters A and B.
// Each requester has a req/we/addr/wdata/lock input set and gnt/rvalid/rdata outputs.
// Grants are combinational; mem_in/mem_load/mem_address drive the RAM.
// mem_out is the RAM's combinational read data. busy flags the clear sequence.
// Round-robin on contention; a lock holds ownership for RMW sequences.
// Optional macro RAM4K_ARB_CLEAR_EN enables the power-on clear sequencer.
module ram4k_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

    owner_e            own_q, own_d;
    logic              last_b_q, last_b_d;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              run;

`ifdef RAM4K_ARB_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == ST_CLEAR) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    assign run  = (state_q == ST_RUN);
    assign busy = !run;
`else
    logic unused_clear_val;

    assign unused_clear_val = ^CLEAR_VAL;
    assign run              = 1'b1;
    assign busy             = 1'b0;
`endif

    // A locked owner excludes the other side even while it is idle.
    // On a tie the side that did not win last time goes first.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (run) begin
            case (own_q)
                OWN_A: a_gnt = a_req;
                OWN_B: b_gnt = b_req;
                default: begin
                    if (a_req && b_req) begin
                        a_gnt = last_b_q;
                        b_gnt = !last_b_q;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        if (a_gnt) begin
            mem_load    = a_we;
            mem_address = a_addr;
            mem_in      = a_wdata;
        end else if (b_gnt) begin
            mem_load    = b_we;
            mem_address = b_addr;
            mem_in      = b_wdata;
        end
`ifdef RAM4K_ARB_CLEAR_EN
        if (!run) begin
            mem_load    = 1'b1;
            mem_address = clr_q;
            mem_in      = CLEAR_VAL;
        end
`endif
    end

    // Release first, then let a granted locker (re)claim ownership.
    always_comb begin
        own_d    = own_q;
        last_b_d = last_b_q;
        if (own_q == OWN_A && !a_lock) own_d = OWN_NONE;
        if (own_q == OWN_B && !b_lock) own_d = OWN_NONE;
        if (a_gnt) begin
            last_b_d = 1'b0;
            if (a_lock) own_d = OWN_A;
        end
        if (b_gnt) begin
            last_b_d = 1'b1;
            if (b_lock) own_d = OWN_B;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            own_q      <= OWN_NONE;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            own_q      <= own_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_gnt && !a_we;
            b_rvalid_q <= b_gnt && !b_we;
            if (a_gnt && !a_we) a_rdata_q <= mem_out;
            if (b_gnt && !b_we) b_rdata_q <= mem_out;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule
